// File: rtl/ml_enc_pkg.sv
// Shared constants, state encoding and popcount helper for the 64-to-6 line encoder.
package ml_enc_pkg;

  localparam int unsigned N_LINES = 64;
  localparam int unsigned AW      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of set bits in a line vector (0..N_LINES).
  function automatic logic [AW:0] popcount(input logic [N_LINES-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N_LINES); i++) begin
      cnt = cnt + (AW+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_enc_64.sv
// Combinational lowest-set-bit encoder.
//   vec     : input vector
//   idx     : index of the lowest set bit (0 when vec is zero)
//   one_hot : vec has exactly one bit set
module prio_enc_64
  import ml_enc_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  output logic [AW-1:0]      idx,
  output logic               one_hot
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
      if (vec[i]) idx = AW'(i);
    end
  end

  assign one_hot = (vec != '0) && ((vec & (vec - N_LINES'(1))) == '0);

endmodule

// File: rtl/ml_enc_64to6.sv
// Sequential 64-to-6 line encoder: captures an active-low line vector on start
// and streams the index of every asserted line, lowest first, over valid/ready.
//   clk, rst_n     : clock, async active-low reset
//   line_n         : line vector, bit low = line asserted (sampled on accepted start)
//   start          : capture request, honoured only in IDLE
//   busy           : high in SCAN and DONE
//   addr_valid/ready, addr, addr_last : index stream
//   done           : one-cycle pulse at end of capture
//   hit_cnt, no_hit, multi_hit : result of the last capture
module ml_enc_64to6
  import ml_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] line_n,
  input  logic               start,
  output logic               busy,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [AW-1:0]      addr,
  output logic               addr_last,
  output logic               done,
  output logic [AW:0]        hit_cnt,
  output logic               no_hit,
  output logic               multi_hit
);

  state_e             state_q, state_d;
  logic [N_LINES-1:0] pend_q, pend_d;
  logic [AW:0]        hit_cnt_q, hit_cnt_d;
  logic               no_hit_q, no_hit_d;
  logic               multi_hit_q, multi_hit_d;

  logic [AW-1:0]      low_idx;
  logic               low_one_hot;
  logic [N_LINES-1:0] cap_vec;
  logic [AW:0]        cap_cnt;

  prio_enc_64 u_prio (
    .vec     (pend_q),
    .idx     (low_idx),
    .one_hot (low_one_hot)
  );

  assign cap_vec = ~line_n;
  assign cap_cnt = popcount(cap_vec);

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      hit_cnt_q   <= '0;
      no_hit_q    <= 1'b0;
      multi_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hit_cnt_q   <= hit_cnt_d;
      no_hit_q    <= no_hit_d;
      multi_hit_q <= multi_hit_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    hit_cnt_d   = hit_cnt_q;
    no_hit_d    = no_hit_q;
    multi_hit_d = multi_hit_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d      = cap_vec;
          hit_cnt_d   = cap_cnt;
          no_hit_d    = (cap_cnt == '0);
          multi_hit_d = (cap_cnt >= (AW+1)'(2));
          state_d     = (cap_vec != '0) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        if (addr_ready) begin
          // Clear the lowest set bit, which is the index just transferred.
          pend_d = pend_q & (pend_q - N_LINES'(1));
          if (low_one_hot) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  assign addr_valid = (state_q == ST_SCAN);
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign addr       = low_idx;
  assign addr_last  = low_one_hot;
  assign hit_cnt    = hit_cnt_q;
  assign no_hit     = no_hit_q;
  assign multi_hit  = multi_hit_q;

endmodule

// File: doc/ml_enc_64to6.md
# ml_enc_64to6

Sequential 64-to-6 line encoder: the inverse of the 6-to-64 wordline decoder. It captures a 64-bit active-low line vector (wordline or match-line readback), then streams the 6-bit index of every asserted (low) line, in ascending order, through a valid/ready handshake. It sits between the array's line sense/readback and the address-consuming logic. It also serves as the self-check partner of the decoder: a healthy decoder output yields exactly one index and `multi_hit=0`.

## Interface
- `N_LINES`, 64: number of lines; must be a power of two.
- `AW`, 6: index width, equal to log2(`N_LINES`).

- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `line_n` input `N_LINES`: line vector; bit i low means line i is asserted.
- `start` input 1: capture request. Ignored unless the FSM is in IDLE.
- `busy` output 1: high in SCAN and DONE.
- `addr_valid` output 1: `addr` holds a valid index.
- `addr_ready` input 1: consumer accepts `addr`.
- `addr` output `AW`: index of the lowest pending asserted line.
- `addr_last` output 1: the current `addr` is the final index of this capture.
- `done` output 1: one-cycle pulse at the end of every capture.
- `hit_cnt` output `AW+1`: number of asserted lines in the last capture (0..64).
- `no_hit` output 1: the last capture had zero asserted lines.
- `multi_hit` output 1: the last capture had two or more asserted lines.

## Operation
- **States.** IDLE, SCAN, DONE, held in a 2-bit state register.
- **IDLE.**
  - `start=1`: latch `pend <= ~line_n`, latch `hit_cnt` = popcount(~line_n), and update `no_hit`/`multi_hit`.
  - Next state is SCAN if `pend` is nonzero, otherwise DONE.
- **SCAN.**
  - `addr_valid=1`; `addr` = index of the lowest set bit of `pend`.
  - `addr_last=1` when `pend` has exactly one bit set.
  - On `addr_valid & addr_ready`: clear that bit in `pend`. If `addr_last` was set, go to DONE; otherwise stay in SCAN.
- **DONE.** `done=1` for one cycle, then IDLE. `pend` is zero here.
- **Result hold.** `hit_cnt`, `no_hit` and `multi_hit` hold until the next accepted `start`.
- **Handshake.** While `addr_valid=1` and `addr_ready=0`, `addr` and `addr_last` stay stable. `addr_valid` never drops without a transfer.
- **Input sampling.** `line_n` is sampled only on the accepted-`start` edge; later changes have no effect.
- **Start while busy.** `start` asserted in SCAN or DONE is dropped, not queued.
- **Reset values.** All outputs and registers are 0: state=IDLE, `pend`=0, `addr`=0, `addr_valid`=0, `addr_last`=0, `done`=0, `busy`=0, `hit_cnt`=0, `no_hit`=0, `multi_hit`=0.
- **Reset mid-operation.** An asynchronous reset aborts the scan immediately. Pending indices are discarded and no `done` pulse is issued.

## Timing
- **Start to first index.** `start` sampled at edge k gives `addr_valid=1` in the cycle after edge k.
- **Throughput.** One index per cycle when `addr_ready` is held high.
- **Scan length.** n hits with `addr_ready` held high: indices appear in cycles k+1..k+n, and `done` is high in cycle k+n+1.
- **Zero hits.** `done` is high in cycle k+1 with `addr_valid` never asserted. `no_hit=1`, `hit_cnt=0`.
- **Result visibility.** `hit_cnt`, `no_hit` and `multi_hit` are valid from cycle k+1.
- **Back-to-back captures.** `start` may be asserted in the cycle `done` is high but is ignored. The earliest accepted `start` is the first cycle back in IDLE.
- **Output timing.** `addr` and `addr_last` are combinational from registered `pend` only, with no input-to-output paths. `addr_valid`, `busy` and `done` decode from the state register.

## Structure
- **Package `ml_enc_pkg`:**
  - `N_LINES` and `AW` constants.
  - State encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - popcount function.
- **Sub-module `prio_enc_64`.** Combinational lowest-set-bit encoder with inputs `vec[N_LINES-1:0]` and outputs `idx[AW-1:0]` and `one_hot` (exactly one bit set). It is instantiated once on `pend`.

## Test plan
1. **Single hit:** after reset, `line_n` = all-ones except bit 37 low, `start` pulse, `addr_ready=1` -> one transfer with `addr=37` and `addr_last=1`; `hit_cnt=1`, `multi_hit=0`, `done` high 2 cycles after the start edge.
2. **Multi-hit with backpressure:** `line_n` low at bits 0, 5 and 63; `addr_ready` low for 3 cycles, then high -> `addr=0` held stable while stalled; then 0, 5, 63 in order with `addr_last` only on 63; `hit_cnt=3`, `multi_hit=1`.
3. **No hit:** `line_n` all-ones, `start` -> `addr_valid` stays 0, `done` one cycle after the start edge, `no_hit=1`, `hit_cnt=0`.
4. **Full vector:** `line_n`=0 -> indices 0..63 in 64 consecutive cycles; `hit_cnt=64`; `addr_last` only on index 63.
5. **Decoder loopback:** drive `line_n` from the 6-to-64 decoder for every address 0..63 -> each capture returns the same address, `hit_cnt=1`, `multi_hit=0`.
6. **Start ignored, then reset mid-scan:** `start` pulsed in SCAN -> no effect. Then `rst_n` low mid-scan with `line_n` low at bits 2 and 9, after index 2 has transferred -> all outputs 0 immediately, no `done` pulse, index 9 never emitted. After reset release, a new capture behaves normally.
